// File: rtl/array_arbiter_pkg.sv
// Shared types and defaults for the two-client array port arbiter.
// The debug struct gives checkers direct visibility of the arbiter FSM.
package array_arbiter_pkg;

    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 32;
    localparam int LOCK_MAX_DEF = 8;
    localparam int LOCK_CNT_W   = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        arb_state_t            state;
        logic                  last;
        logic [LOCK_CNT_W-1:0] lock_cnt;
    } arb_dbg_t;

    // True on the cycle whose closing edge must force a lock release.
    function automatic logic lock_expired(input logic [LOCK_CNT_W-1:0] cnt,
                                          input int                    lock_max);
        return cnt == LOCK_CNT_W'(lock_max - 1);
    endfunction

endpackage

// File: rtl/array_arbiter_rr_pick2.sv
// Combinational two-way grant selection: round-robin in ARB, pinned
// to the lock owner in LOCK0/LOCK1.
module rr_pick2
    import array_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  arb_state_t state,
    output logic       grant
);

    always_comb begin
        grant = ~last;
        case (state)
            ARB: begin
                if (valid0 && !valid1) begin
                    grant = 1'b0;
                end else if (valid1 && !valid0) begin
                    grant = 1'b1;
                end else begin
                    // Contention and idle both favour the client not served last.
                    grant = ~last;
                end
            end
            LOCK0:   grant = 1'b0;
            LOCK1:   grant = 1'b1;
            default: grant = ~last;
        endcase
    end

endmodule

// File: rtl/array_arbiter.sv
// Shares one asynchronous-read / synchronous-write array port between two
// clients with round-robin arbitration, bounded locking and registered reads.
module array_arbiter
    import array_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c0_valid,
    output logic              c0_ready,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_we,
    input  logic [DATA_W-1:0] c0_di,
    input  logic              c0_lock,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,

    input  logic              c1_valid,
    output logic              c1_ready,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_we,
    input  logic [DATA_W-1:0] c1_di,
    input  logic              c1_lock,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [DATA_W-1:0] m_di,
    input  logic [DATA_W-1:0] m_do,

    output arb_dbg_t          dbg
);

    // Handshake: a transfer happens on any edge where valid && ready; a client
    // holds valid, addr, we, di and lock stable until then, and ready is only
    // ever raised for the granted client while the array reports m_ready.

    arb_state_t            state_q, state_d;
    logic                  last_q, last_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic                  grant;
    logic                  sel_valid;
    logic                  sel_lock;
    logic                  xfer;
    logic                  expired;
    logic                  rd0, rd1;

    rr_pick2 u_pick (
        .valid0 (c0_valid),
        .valid1 (c1_valid),
        .last   (last_q),
        .state  (state_q),
        .grant  (grant)
    );

    assign sel_valid = grant ? c1_valid : c0_valid;
    assign sel_lock  = grant ? c1_lock  : c0_lock;
    assign m_addr    = grant ? c1_addr  : c0_addr;
    assign m_we      = grant ? c1_we    : c0_we;
    assign m_di      = grant ? c1_di    : c0_di;

    // Gating with rst_n keeps the array quiet while reset is held.
    assign m_valid   = rst_n && sel_valid;
    assign xfer      = m_valid && m_ready;
    assign c0_ready  = xfer && !grant;
    assign c1_ready  = xfer && grant;

    assign rd0       = c0_ready && !c0_we;
    assign rd1       = c1_ready && !c1_we;

    assign expired   = (state_q != ARB) && lock_expired(lock_cnt_q, LOCK_MAX);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (xfer) begin
                    last_d = grant;
                    if (sel_lock) begin
                        state_d    = grant ? LOCK1 : LOCK0;
                        lock_cnt_d = '0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                // Counts through stalls too, so the hold time is bounded in cycles.
                lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                if (expired || (xfer && !sel_lock)) begin
                    state_d = ARB;
                    last_d  = grant;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            c0_rvalid  <= 1'b0;
            c1_rvalid  <= 1'b0;
            c0_rdata   <= '0;
            c1_rdata   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            c0_rvalid  <= rd0;
            c1_rvalid  <= rd1;
            if (rd0) begin
                c0_rdata <= m_do;
            end
            if (rd1) begin
                c1_rdata <= m_do;
            end
        end
    end

    assign dbg = {state_q, last_q, lock_cnt_q};

endmodule

// File: tb/tb_array_arbiter.sv
// Directed bench for array_arbiter with a behavioural array and a read-data
// scoreboard per client; built with LOCK_MAX = 4 so the timeout is reachable.
module tb_array_arbiter;
    import array_arbiter_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c0_valid, c0_we, c0_lock, c0_ready, c0_rvalid;
    logic [AW-1:0] c0_addr;
    logic [DW-1:0] c0_di, c0_rdata;
    logic          c1_valid, c1_we, c1_lock, c1_ready, c1_rvalid;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c1_di, c1_rdata;
    logic          m_valid, m_ready, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_di, m_do;
    arb_dbg_t      dbg;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    array_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_addr(c0_addr), .c0_we(c0_we),
        .c0_di(c0_di), .c0_lock(c0_lock), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_addr(c1_addr), .c1_we(c1_we),
        .c1_di(c1_di), .c1_lock(c1_lock), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_we(m_we),
        .m_di(m_di), .m_do(m_do), .dbg(dbg)
    );

    // Behavioural array: data[i] = i after every reset, async read, sync write.
    assign m_do = mem[m_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= DW'(i);
        end else if (m_valid && m_ready && m_we) begin
            mem[m_addr] <= m_di;
        end
    end

    task automatic drive0(input logic v, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] di, input logic lk);
        c0_valid = v; c0_addr = a; c0_we = we; c0_di = di; c0_lock = lk;
    endtask

    task automatic drive1(input logic v, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] di, input logic lk);
        c1_valid = v; c1_addr = a; c1_we = we; c1_di = di; c1_lock = lk;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ready = 1'b1;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic go_idle();
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_ready = 1'b1;
        drive0(1, 7, 0, 0, 0);
        drive1(1, 9, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (c0_ready !== 1'b0 || c1_ready !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: ready0=%b ready1=%b m_valid=%b want 0 0 0",
                         i, c0_ready, c1_ready, m_valid);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0 || dbg.state !== ARB || dbg.last !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_regs cyc %0d: rvalid=%b%b state=%0d last=%b want 00 0 1",
                         i, c0_rvalid, c1_rvalid, dbg.state, dbg.last);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (c0_ready !== 1'b1 || c1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_grant: ready0=%b ready1=%b want 1 0", c0_ready, c1_ready);
        end
        exp_q0.push_back(32'd7);
        @(posedge clk);
        #1;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        vectors++;
        if (c0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_rvalid: got %b want 1", c0_rvalid);
        end else begin
            logic [DW-1:0] d;
            d = exp_q0.pop_front();
            vectors++;
            if (c0_rdata !== d) begin
                miscompares++;
                $display("FAIL reset_first_rdata: got %0h want %0h", c0_rdata, d);
            end
        end
        go_idle();
    endtask

    task automatic test_contention();
        logic e0, e1;
        logic [DW-1:0] d;
        do_reset();
        drive0(1, 3, 0, 0, 0);
        drive1(1, 5, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            e0 = (i % 2 == 0);
            e1 = !e0;
            @(negedge clk);
            vectors++;
            if (c0_ready !== e0 || c1_ready !== e1) begin
                miscompares++;
                $display("FAIL contention_grant cyc %0d: ready=%b%b want %b%b", i, c0_ready, c1_ready, e0, e1);
            end
            if (e0) exp_q0.push_back(32'd3);
            if (e1) exp_q1.push_back(32'd5);
            @(posedge clk);
            #1;
            vectors++;
            if (c0_rvalid !== e0 || c1_rvalid !== e1) begin
                miscompares++;
                $display("FAIL contention_rvalid cyc %0d: rvalid=%b%b want %b%b", i, c0_rvalid, c1_rvalid, e0, e1);
            end
            if (e0) begin
                d = exp_q0.pop_front();
                vectors++;
                if (c0_rdata !== d) begin
                    miscompares++;
                    $display("FAIL contention_rdata0 cyc %0d: got %0h want %0h", i, c0_rdata, d);
                end
            end
            if (e1) begin
                d = exp_q1.pop_front();
                vectors++;
                if (c1_rdata !== d) begin
                    miscompares++;
                    $display("FAIL contention_rdata1 cyc %0d: got %0h want %0h", i, c1_rdata, d);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        do_reset();
        drive0(1, 2, 1, 32'hAA, 0);
        drive1(0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (c0_ready !== 1'b1 || c1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_accept: ready=%b%b want 10", c0_ready, c1_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_no_rvalid: rvalid=%b%b want 00", c0_rvalid, c1_rvalid);
        end
        drive0(0, 0, 0, 0, 0);
        drive1(1, 2, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (c1_ready !== 1'b1 || c0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_accept: ready=%b%b want 01", c0_ready, c1_ready);
        end
        exp_q1.push_back(32'hAA);
        @(posedge clk);
        #1;
        drive1(0, 0, 0, 0, 0);
        vectors++;
        if (c1_rvalid !== 1'b1 || c0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_rvalid: rvalid=%b%b want 01", c0_rvalid, c1_rvalid);
        end else begin
            d = exp_q1.pop_front();
            vectors++;
            if (c1_rdata !== d) begin
                miscompares++;
                $display("FAIL rd_after_wr_data: got %0h want %0h", c1_rdata, d);
            end
        end
        go_idle();
    endtask

    // Per-cycle table: c0 locks a read, idles one locked cycle, then unlocks
    // with a write; c1 waits throughout and is served afterwards.
    task automatic test_lock_release();
        logic e0, e1, rv0, rv1;
        logic [DW-1:0] d0, d1, d;
        arb_state_t es;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            e0 = 0; e1 = 0; d0 = 0; d1 = 0; es = ARB;
            case (i)
                0: begin drive0(1, 1, 0, 0, 1); drive1(1, 5, 0, 0, 0); e0 = 1; d0 = 32'd1; es = LOCK0; end
                1: begin drive0(0, 1, 0, 0, 1); es = LOCK0; end
                2: begin drive0(1, 1, 1, 32'h55, 0); e0 = 1; es = ARB; end
                3: begin drive0(0, 0, 0, 0, 0); e1 = 1; d1 = 32'd5; es = ARB; end
                default: begin drive0(1, 1, 0, 0, 0); drive1(0, 0, 0, 0, 0); e0 = 1; d0 = 32'h55; es = ARB; end
            endcase
            @(negedge clk);
            vectors++;
            if (c0_ready !== e0 || c1_ready !== e1) begin
                miscompares++;
                $display("FAIL lock_grant cyc %0d: ready=%b%b want %b%b", i, c0_ready, c1_ready, e0, e1);
            end
            rv0 = e0 && !c0_we;
            rv1 = e1 && !c1_we;
            if (rv0) exp_q0.push_back(d0);
            if (rv1) exp_q1.push_back(d1);
            @(posedge clk);
            #1;
            vectors++;
            if (c0_rvalid !== rv0 || c1_rvalid !== rv1 || dbg.state !== es) begin
                miscompares++;
                $display("FAIL lock_resp cyc %0d: rvalid=%b%b state=%0d want %b%b %0d",
                         i, c0_rvalid, c1_rvalid, dbg.state, rv0, rv1, es);
            end
            if (rv0) begin
                d = exp_q0.pop_front();
                vectors++;
                if (c0_rdata !== d) begin
                    miscompares++;
                    $display("FAIL lock_rdata0 cyc %0d: got %0h want %0h", i, c0_rdata, d);
                end
            end
            if (rv1) begin
                d = exp_q1.pop_front();
                vectors++;
                if (c1_rdata !== d) begin
                    miscompares++;
                    $display("FAIL lock_rdata1 cyc %0d: got %0h want %0h", i, c1_rdata, d);
                end
            end
        end
        go_idle();
    endtask

    // c0 keeps lock asserted: one entering grant plus LM locked grants, the
    // last of which is the forced-release edge; c1 follows immediately.
    task automatic test_lock_timeout();
        logic e0, e1;
        logic [DW-1:0] d;
        arb_state_t es;
        do_reset();
        drive0(1, 4, 0, 0, 1);
        drive1(1, 6, 0, 0, 0);
        for (int i = 0; i < LM + 2; i++) begin
            e0 = (i <= LM);
            e1 = (i == LM + 1);
            es = (i < LM) ? LOCK0 : ARB;
            @(negedge clk);
            vectors++;
            if (c0_ready !== e0 || c1_ready !== e1) begin
                miscompares++;
                $display("FAIL timeout_grant cyc %0d: ready=%b%b want %b%b", i, c0_ready, c1_ready, e0, e1);
            end
            if (e0) exp_q0.push_back(32'd4);
            if (e1) exp_q1.push_back(32'd6);
            @(posedge clk);
            #1;
            vectors++;
            if (c0_rvalid !== e0 || c1_rvalid !== e1 || dbg.state !== es) begin
                miscompares++;
                $display("FAIL timeout_resp cyc %0d: rvalid=%b%b state=%0d want %b%b %0d",
                         i, c0_rvalid, c1_rvalid, dbg.state, e0, e1, es);
            end
            if (e0) begin
                d = exp_q0.pop_front();
                vectors++;
                if (c0_rdata !== d) begin
                    miscompares++;
                    $display("FAIL timeout_rdata0 cyc %0d: got %0h want %0h", i, c0_rdata, d);
                end
            end
            if (e1) begin
                d = exp_q1.pop_front();
                vectors++;
                if (c1_rdata !== d) begin
                    miscompares++;
                    $display("FAIL timeout_rdata1 cyc %0d: got %0h want %0h", i, c1_rdata, d);
                end
            end
        end
        go_idle();
    endtask

    // Two stalled cycles, then c0 and a locking c1 read, then reset while in LOCK1.
    task automatic test_stall_reset();
        logic e0, e1, em, el;
        logic [DW-1:0] d;
        arb_state_t es;
        do_reset();
        drive0(1, 3, 0, 0, 0);
        drive1(1, 6, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            m_ready = (i >= 2);
            rst_n   = (i != 4);
            e0 = (i == 2) || (i == 5);
            e1 = (i == 3);
            em = (i != 4);
            el = (i == 2) || (i == 5) ? 1'b0 : 1'b1;
            es = (i == 3) ? LOCK1 : ARB;
            @(negedge clk);
            vectors++;
            if (c0_ready !== e0 || c1_ready !== e1 || m_valid !== em) begin
                miscompares++;
                $display("FAIL stall_grant cyc %0d: ready=%b%b m_valid=%b want %b%b %b",
                         i, c0_ready, c1_ready, m_valid, e0, e1, em);
            end
            if (e0) exp_q0.push_back(32'd3);
            if (e1) exp_q1.push_back(32'd6);
            @(posedge clk);
            #1;
            vectors++;
            if (c0_rvalid !== e0 || c1_rvalid !== e1 || dbg.state !== es || dbg.last !== el) begin
                miscompares++;
                $display("FAIL stall_resp cyc %0d: rvalid=%b%b state=%0d last=%b want %b%b %0d %b",
                         i, c0_rvalid, c1_rvalid, dbg.state, dbg.last, e0, e1, es, el);
            end
            if (e0) begin
                d = exp_q0.pop_front();
                vectors++;
                if (c0_rdata !== d) begin
                    miscompares++;
                    $display("FAIL stall_rdata0 cyc %0d: got %0h want %0h", i, c0_rdata, d);
                end
            end
            if (e1) begin
                d = exp_q1.pop_front();
                vectors++;
                if (c1_rdata !== d) begin
                    miscompares++;
                    $display("FAIL stall_rdata1 cyc %0d: got %0h want %0h", i, c1_rdata, d);
                end
            end
            if (i == 4) begin
                vectors++;
                if (c0_rdata !== '0 || c1_rdata !== '0) begin
                    miscompares++;
                    $display("FAIL reset_rdata_clear: rdata0=%0h rdata1=%0h want 0 0", c0_rdata, c1_rdata);
                end
            end
        end
        m_ready = 1'b1;
        rst_n   = 1'b1;
        go_idle();
    endtask

    initial begin
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        test_reset();
        test_contention();
        test_write_read();
        test_lock_release();
        test_lock_timeout();
        test_stall_reset();
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: left %0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
